// File: rtl/obs_render_multi.sv
// Multi-slot obstacle renderer: per-line vertical pre-scan of shadowed slots,
// then priority horizontal hit test driving a registered sprite-ROM address.
module obs_render_multi #(
   parameter int CONV       = 0,
   parameter int N_OBS      = 3,
   parameter int TYPE_W     = 3,
   parameter int SPR_W_LOG2 = 1,
   parameter int SPR_H_LOG2 = 2,
   parameter int Y_TOP      = 30,
   localparam int W         = 10 - CONV,
   localparam int AW        = TYPE_W + SPR_H_LOG2 + SPR_W_LOG2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [W-1:0]          i_hpos,
   input  logic [W-1:0]          i_vpos,
   input  logic                  i_line_start,
   input  logic [N_OBS-1:0]      i_obs_valid,
   input  logic [N_OBS*TYPE_W-1:0] i_obs_type,
   input  logic [N_OBS*10-1:0]   i_obs_xpos,
   output logic [AW-1:0]         o_rom_addr,
   input  logic                  i_sprite_color,
   output logic                  o_color_obs,
   output logic                  o_busy,
   output logic [N_OBS-1:0]      o_row_mask
);

   localparam int IW = (N_OBS > 1) ? $clog2(N_OBS) : 1;
   localparam logic [W-1:0] H_LIM = W'(2 ** SPR_H_LOG2);
   localparam logic [W-1:0] W_LIM = W'(2 ** SPR_W_LOG2);
   localparam logic [IW-1:0] LAST = IW'(N_OBS - 1);

   typedef enum logic [1:0] {IDLE, SCAN, READY} state_t;

   state_t                  state, state_nx;
   logic [IW-1:0]           idx;
   logic [N_OBS-1:0]        valid_sh;
   logic [N_OBS*TYPE_W-1:0] type_sh;
   logic [N_OBS*10-1:0]     xpos_sh;
   logic [W-1:0]            y_off;
   logic                    hit_q;
   logic                    hit;
   logic [AW-1:0]           addr_nx;
   logic [W-1:0]            x_off;

   always_comb begin
      state_nx = state;
      if (i_line_start) begin
         state_nx = SCAN;
      end else begin
         case (state)
            SCAN:    if (idx == LAST) state_nx = READY;
            default: state_nx = state;
         endcase
      end
   end

   // Descending walk so the lowest-index hitting slot is the one that sticks.
   always_comb begin
      hit     = 1'b0;
      addr_nx = o_rom_addr;
      x_off   = '0;
      if (state == READY) begin
         for (int k = N_OBS - 1; k >= 0; k--) begin
            x_off = i_hpos - xpos_sh[k*10+CONV +: W];
            if (o_row_mask[k] && (x_off < W_LIM)) begin
               hit     = 1'b1;
               addr_nx = {type_sh[k*TYPE_W +: TYPE_W],
                          y_off[SPR_H_LOG2-1:0],
                          x_off[SPR_W_LOG2-1:0]};
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         idx        <= '0;
         valid_sh   <= '0;
         type_sh    <= '0;
         xpos_sh    <= '0;
         y_off      <= '0;
         o_row_mask <= '0;
         o_rom_addr <= '0;
         hit_q      <= 1'b0;
         o_color_obs <= 1'b0;
      end else begin
         state       <= state_nx;
         hit_q       <= hit;
         o_rom_addr  <= addr_nx;
         o_color_obs <= hit_q & i_sprite_color;
         if (i_line_start) begin
            valid_sh   <= i_obs_valid;
            type_sh    <= i_obs_type;
            xpos_sh    <= i_obs_xpos;
            y_off      <= i_vpos - W'(Y_TOP);
            o_row_mask <= '0;
            idx        <= '0;
         end else if (state == SCAN) begin
            o_row_mask[idx] <= valid_sh[idx] && (y_off < H_LIM);
            if (idx != LAST) idx <= idx + 1'b1;
         end
      end
   end

   assign o_busy = (state == SCAN);

endmodule

// File: doc/obs_render_multi.md
# obs_render_multi

Parametrised multi-slot obstacle renderer, successor to the single-obstacle renderer in the Dino graphics path. At each line start it snapshots up to N_OBS obstacle slots and runs a per-line vertical pre-scan FSM. During the visible line it selects the highest-priority horizontally hit slot and drives a registered sprite-ROM address. It returns a pipelined 1-bit obstacle colour to the pixel mixer.

## Interface
Parameters:
- CONV, 0: coordinate downscale shift; screen coordinates are W = 10-CONV bits.
- N_OBS, 3: number of obstacle slots, 1..8.
- TYPE_W, 3: obstacle type width; selects the sprite in ROM.
- SPR_W_LOG2, 1: log2 of sprite width in scaled pixels.
- SPR_H_LOG2, 2: log2 of sprite height in scaled pixels.
- Y_TOP, 30: first scaled row of the obstacle band.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- i_hpos  in  W  scaled horizontal position.
- i_vpos  in  W  scaled vertical position; must already hold the row to be drawn when i_line_start pulses.
- i_line_start  in  1  one-cycle pulse in horizontal blank, at least N_OBS+1 cycles before the first visible pixel.
- i_obs_valid  in  N_OBS  slot k enabled.
- i_obs_type  in  N_OBS*TYPE_W  slot k at [k*TYPE_W +: TYPE_W].
- i_obs_xpos  in  N_OBS*10  full-resolution x; slot k at [k*10 +: 10]; compared as bits [9:CONV].
- o_rom_addr  out  TYPE_W+SPR_H_LOG2+SPR_W_LOG2  {type, row, col}, registered.
- i_sprite_color  in  1  combinational ROM data for the current o_rom_addr.
- o_color_obs  out  1  obstacle pixel, registered.
- o_busy  out  1  high while the pre-scan runs.
- o_row_mask  out  N_OBS  slots that intersect the current line, registered.

## Operation
- Reset values: FSM IDLE, scan index 0, shadow registers 0, o_row_mask 0, o_rom_addr 0, hit_q 0, o_color_obs 0, o_busy 0.
- The FSM has three states: IDLE, SCAN and READY.
- Any state, on i_line_start:
  - snapshot i_obs_valid, i_obs_type, i_obs_xpos and i_vpos into shadow registers;
  - set y_off = i_vpos - Y_TOP, modulo 2^W;
  - clear o_row_mask, set index 0, go to SCAN.
- SCAN: one slot per cycle. o_row_mask[idx] <= valid_sh[idx] && (y_off < 2^SPR_H_LOG2). When idx = N_OBS-1, go to READY the next cycle. o_busy = (state == SCAN).
- i_line_start during SCAN restarts the scan from the new snapshot. Partial results are discarded.
- Mid-line changes to the i_obs_* inputs have no effect until the next i_line_start; there is no tearing.
- READY, draw stage 1 (per cycle):
  - for each slot k with o_row_mask[k], x_off_k = i_hpos - xpos_sh[k][9:CONV], modulo 2^W;
  - slot k hits if x_off_k < 2^SPR_W_LOG2;
  - the lowest-index hitting slot wins;
  - on a hit: hit_q <= 1 and o_rom_addr <= {type_sh[k], y_off[SPR_H_LOG2-1:0], x_off_k[SPR_W_LOG2-1:0]};
  - on no hit: hit_q <= 0 and o_rom_addr holds its previous value.
- IDLE or SCAN: hit_q <= 0 and o_rom_addr holds.
- Draw stage 2: o_color_obs <= hit_q & i_sprite_color.
- Wrap-around is intentional. A sprite whose x is near 2^W-1 splits across the screen edge. Example with CONV=0 and SPR_W=2, xpos=1023: col 0 draws at hpos 1023 and col 1 at hpos 0.
- Overlapping slots: only the lowest index draws; the others are fully occluded, with no OR of colours.

## Timing
- Pre-scan: SCAN lasts exactly N_OBS cycles after the i_line_start edge. READY is entered on cycle N_OBS+1.
- Pixel latency: for i_hpos presented in cycle t, o_rom_addr is valid in t+1 and o_color_obs in t+2. The mixer compensates with a 2-pixel shift.
- o_rom_addr changes only on clock edges. The ROM must be combinational within one cycle.
- Reset asserted mid-line forces o_color_obs and o_busy low asynchronously. After deassertion nothing draws until the next i_line_start.

## Test plan
- **Reset mid-scan:** assert rst during SCAN, then release. Required: o_busy=0 and o_color_obs=0 until the next i_line_start; the scan then completes with o_busy high for N_OBS cycles.
- **Single slot draw:** N_OBS=3, CONV=0; slot 0 valid, type 2, xpos=100; vpos=31; ROM returns 1. Required:
  - o_row_mask=3'b001;
  - o_rom_addr={2,1,0} at hpos 100 and {2,1,1} at hpos 101, each visible the next cycle;
  - o_color_obs=1 exactly two cycles after hpos 100 and 101, and 0 elsewhere.
- **Vertical bounds:** vpos=29 and vpos=34 give o_row_mask=0 and no colour. vpos=30 and vpos=33 draw.
- **Priority:** slots 0 and 2 both at xpos=200, with types 1 and 5. Required: o_rom_addr type field = 1; slot 2 is never addressed.
- **Edge wrap:** xpos=1023. Required: col 0 at hpos 1023 and col 1 at hpos 0 of the same line.
- **Snapshot and restart:**
  - change xpos mid-line: the drawn position is unchanged until the next line;
  - pulse i_line_start again one cycle into SCAN: o_busy stays high for N_OBS cycles from the second pulse.
